// File: rtl/i2s_sample_rx.sv
// I2S receiver front end: oversamples sck/ws/sd in the clk_i domain, extracts one channel
// as a signed word, rate-limits accepted samples to MIN_GAP and flags link errors.
module i2s_sample_rx #(
   parameter int DWIDTH  = 16,
   parameter int CHANNEL = 0,
   parameter int MIN_GAP = 515
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              sck_i,
   input  logic              ws_i,
   input  logic              sd_i,
   input  logic              clr_err_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              sample_tick_o,
   output logic              frame_err_o,
   output logic              overrun_o
);

   localparam int CW = $clog2(DWIDTH + 1);
   localparam int GW = $clog2(MIN_GAP + 1);
   localparam logic [CW-1:0] DW_C    = CW'(DWIDTH);
   localparam logic [CW-1:0] DW_M1_C = CW'(DWIDTH - 1);
   localparam logic [GW-1:0] GAP_C   = GW'(MIN_GAP);
   localparam logic          CH_C    = 1'(CHANNEL);

   logic [2:0]        sck_sync_q, sck_sync_d;
   logic [1:0]        ws_sync_q, ws_sync_d;
   logic [1:0]        sd_sync_q, sd_sync_d;
   logic              ws_prev_q, ws_prev_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DWIDTH-1:0] shreg_q, shreg_d;
   logic              armed_q, armed_d;
   logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
   logic [DWIDTH-1:0] data_q, data_d;
   logic              tick_q, tick_d;
   logic              frame_err_q, frame_err_d;
   logic              overrun_q, overrun_d;

   logic              rise_s;
   logic              ws_s;
   logic              sd_s;
   logic              shift_en_s;
   logic [DWIDTH-1:0] shifted_s;
   logic [DWIDTH-1:0] word_s;
   logic              full_s;

   assign rise_s = sck_sync_q[1] & ~sck_sync_q[2];
   assign ws_s   = ws_sync_q[1];
   assign sd_s   = sd_sync_q[1];

   // Next-state logic: synchronizers, slot assembly, accept/drop decision and sticky flags
   always_comb begin
      sck_sync_d  = {sck_sync_q[1:0], sck_i};
      ws_sync_d   = {ws_sync_q[0], ws_i};
      sd_sync_d   = {sd_sync_q[0], sd_i};
      ws_prev_d   = ws_prev_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      armed_d     = armed_q;
      data_d      = data_q;
      tick_d      = 1'b0;
      shift_en_s  = (bit_cnt_q < DW_C);
      shifted_s   = {shreg_q[DWIDTH-2:0], sd_s};
      // the boundary bit completes the slot only while there is still room for it
      if (shift_en_s) begin
         word_s = shifted_s;
         full_s = (bit_cnt_q == DW_M1_C);
      end else begin
         word_s = shreg_q;
         full_s = 1'b1;
      end
      if (gap_cnt_q < GAP_C) begin
         gap_cnt_d = gap_cnt_q + GW'(1);
      end else begin
         gap_cnt_d = gap_cnt_q;
      end
      if (clr_err_i) begin
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end else begin
         frame_err_d = frame_err_q;
         overrun_d   = overrun_q;
      end

      if (rise_s) begin
         ws_prev_d = ws_s;
         if (ws_s == ws_prev_q) begin
            if (shift_en_s) begin
               shreg_d   = shifted_s;
               bit_cnt_d = bit_cnt_q + CW'(1);
            end else begin
               bit_cnt_d = bit_cnt_q;
            end
         end else begin
            bit_cnt_d = {CW{1'b0}};
            if (!armed_q) begin
               armed_d = 1'b1;
            end else if (ws_prev_q == CH_C) begin
               if (!full_s) begin
                  frame_err_d = 1'b1;
               end else if (gap_cnt_q >= GAP_C) begin
                  data_d    = word_s;
                  tick_d    = 1'b1;
                  gap_cnt_d = {GW{1'b0}};
               end else begin
                  overrun_d = 1'b1;
               end
            end else begin
               armed_d = armed_q;
            end
         end
      end else begin
         ws_prev_d = ws_prev_q;
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sck_sync_q  <= 3'b000;
         ws_sync_q   <= 2'b00;
         sd_sync_q   <= 2'b00;
         ws_prev_q   <= 1'b0;
         bit_cnt_q   <= {CW{1'b0}};
         shreg_q     <= {DWIDTH{1'b0}};
         armed_q     <= 1'b0;
         gap_cnt_q   <= GAP_C;
         data_q      <= {DWIDTH{1'b0}};
         tick_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         ws_sync_q   <= ws_sync_d;
         sd_sync_q   <= sd_sync_d;
         ws_prev_q   <= ws_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         armed_q     <= armed_d;
         gap_cnt_q   <= gap_cnt_d;
         data_q      <= data_d;
         tick_q      <= tick_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign data_o        = data_q;
   assign sample_tick_o = tick_q;
   assign frame_err_o   = frame_err_q;
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Scoreboard bench for i2s_sample_rx: three instances (left, right, left with the full
// MIN_GAP), each with its own link; a monitor pops expected words whenever a DUT ticks.
module tb_i2s_sample_rx;

   logic        clk;
   logic        rst_n;
   logic        clr_err;
   logic        sck_l [3];
   logic        ws_l  [3];
   logic        sd_l  [3];
   logic [15:0] data_w [3];
   logic        tick_w [3];
   logic        ferr_w [3];
   logic        ovr_w  [3];

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          rise0_cyc [3];
   int          last_tick [3];
   logic        tick_prev [3];
   logic        pend [3];
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   logic [15:0] q2 [$];
   logic [15:0] m_exp;
   logic        m_has;

   i2s_sample_rx #(.DWIDTH(16), .CHANNEL(0), .MIN_GAP(64)) dut_l (
      .clk_i(clk), .rst_n_i(rst_n), .sck_i(sck_l[0]), .ws_i(ws_l[0]), .sd_i(sd_l[0]),
      .clr_err_i(clr_err), .data_o(data_w[0]), .sample_tick_o(tick_w[0]),
      .frame_err_o(ferr_w[0]), .overrun_o(ovr_w[0]));

   i2s_sample_rx #(.DWIDTH(16), .CHANNEL(1), .MIN_GAP(64)) dut_r (
      .clk_i(clk), .rst_n_i(rst_n), .sck_i(sck_l[1]), .ws_i(ws_l[1]), .sd_i(sd_l[1]),
      .clr_err_i(clr_err), .data_o(data_w[1]), .sample_tick_o(tick_w[1]),
      .frame_err_o(ferr_w[1]), .overrun_o(ovr_w[1]));

   i2s_sample_rx #(.DWIDTH(16), .CHANNEL(0), .MIN_GAP(515)) dut_g (
      .clk_i(clk), .rst_n_i(rst_n), .sck_i(sck_l[2]), .ws_i(ws_l[2]), .sd_i(sd_l[2]),
      .clr_err_i(clr_err), .data_o(data_w[2]), .sample_tick_o(tick_w[2]),
      .frame_err_o(ferr_w[2]), .overrun_o(ovr_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic push(input int k, input logic [15:0] v);
      case (k)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   // Monitor: every tick is matched against the scoreboard, its latency, width and spacing
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (tick_w[k] === 1'b1) begin
            m_has = 1'b0;
            m_exp = 16'h0000;
            case (k)
               0: if (q0.size() > 0) begin m_has = 1'b1; m_exp = q0.pop_front(); end
               1: if (q1.size() > 0) begin m_has = 1'b1; m_exp = q1.pop_front(); end
               default: if (q2.size() > 0) begin m_has = 1'b1; m_exp = q2.pop_front(); end
            endcase
            if (!m_has) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_tick dut%0d got data %h want no tick", k, data_w[k]);
            end else begin
               check($sformatf("tick_data_dut%0d", k), data_w[k], m_exp);
            end
            check($sformatf("tick_latency_dut%0d", k), 16'(cyc - rise0_cyc[k]), 16'd3);
            check($sformatf("tick_width_dut%0d", k), {15'd0, tick_prev[k]}, 16'd0);
            check($sformatf("tick_in_reset_dut%0d", k), {15'd0, ~rst_n}, 16'd0);
            if (k == 2 && last_tick[k] >= 0) begin
               check("tick_spacing_ge_515", {15'd0, (cyc - last_tick[k]) >= 515}, 16'd1);
            end
            last_tick[k] = cyc;
         end
         tick_prev[k] = tick_w[k];
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("async_rst_data", data_w[0], 16'h0000);
      check("async_rst_flags", {13'd0, tick_w[0], ferr_w[0], ovr_w[0]}, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One slot of nbits on link k; the first bit period carries the previous slot's LSB.
   task automatic send_slot(input int k, input logic wsv, input logic [31:0] word,
                            input int nbits, input int half, input int abort_at);
      for (int i = 0; i < nbits; i++) begin
         sck_l[k] = 1'b0;
         ws_l[k]  = wsv;
         sd_l[k]  = (i == 0) ? pend[k] : word[32-i];
         if (i == abort_at) do_reset();
         repeat (half) @(posedge clk);
         #1;
         sck_l[k] = 1'b1;
         if (i == 0) rise0_cyc[k] = cyc;
         repeat (half) @(posedge clk);
         #1;
      end
      pend[k] = word[32-nbits];
   endtask

   localparam logic [31:0] LW = 32'hA5C3_0F0F;
   localparam logic [31:0] RW = 32'h1234_5678;

   initial begin
      rst_n   = 1'b0;
      clr_err = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sck_l[k] = 1'b0; ws_l[k] = 1'b0; sd_l[k] = 1'b0; pend[k] = 1'b0;
         rise0_cyc[k] = -100; last_tick[k] = -1; tick_prev[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset_data", data_w[0], 16'h0000);
      check("reset_tick", {15'd0, tick_w[0]}, 16'h0000);
      check("reset_frame_err", {15'd0, ferr_w[0]}, 16'h0000);
      check("reset_overrun", {15'd0, ovr_w[0]}, 16'h0000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // left channel, 32-bit slots, sck = clk/8: first boundary only arms
      send_slot(0, 1'b0, LW, 32, 4, -1);
      send_slot(0, 1'b1, RW, 32, 4, -1);
      send_slot(0, 1'b0, LW, 32, 4, -1);
      push(0, 16'hA5C3);
      send_slot(0, 1'b1, RW, 32, 4, -1);
      send_slot(0, 1'b0, LW, 32, 4, -1);
      push(0, 16'hA5C3);
      send_slot(0, 1'b1, RW, 32, 4, -1);
      send_slot(0, 1'b0, LW, 32, 4, -1);
      push(0, 16'hA5C3);
      send_slot(0, 1'b1, RW, 32, 4, -1);
      check("no_frame_err_good_stream", {15'd0, ferr_w[0]}, 16'h0000);
      check("no_overrun_good_stream", {15'd0, ovr_w[0]}, 16'h0000);

      // 12-bit left slot: frame error, no tick, data held
      send_slot(0, 1'b0, 32'hFFF0_0000, 12, 4, -1);
      send_slot(0, 1'b1, RW, 32, 4, -1);
      check("short_slot_frame_err", {15'd0, ferr_w[0]}, 16'h0001);
      check("short_slot_data_held", data_w[0], 16'hA5C3);
      send_slot(0, 1'b0, 32'h7E81_1111, 32, 4, -1);
      push(0, 16'h7E81);
      send_slot(0, 1'b1, RW, 32, 4, -1);
      check("frame_err_sticky", {15'd0, ferr_w[0]}, 16'h0001);
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      check("frame_err_cleared", {15'd0, ferr_w[0]}, 16'h0000);

      // reset mid left slot: partial slot and the following right slot are not output
      send_slot(0, 1'b0, LW, 32, 4, 10);
      send_slot(0, 1'b1, RW, 32, 4, -1);
      send_slot(0, 1'b0, 32'h5A3C_0000, 32, 4, -1);
      push(0, 16'h5A3C);
      send_slot(0, 1'b1, RW, 32, 4, -1);

      // right channel instance on the same kind of stream
      send_slot(1, 1'b0, LW, 32, 4, -1);
      send_slot(1, 1'b1, RW, 32, 4, -1);
      push(1, 16'h1234);
      send_slot(1, 1'b0, LW, 32, 4, -1);
      send_slot(1, 1'b1, RW, 32, 4, -1);
      push(1, 16'h1234);
      send_slot(1, 1'b0, LW, 32, 4, -1);
      send_slot(1, 1'b1, RW, 32, 4, -1);
      push(1, 16'h1234);
      send_slot(1, 1'b0, LW, 32, 4, -1);
      check("right_inst_no_err", {14'd0, ferr_w[1], ovr_w[1]}, 16'h0000);

      // MIN_GAP=515 with 300-clk frames (25-bit slots, sck = clk/6): every other frame dropped
      send_slot(2, 1'b0, 32'hC001_8000, 25, 3, -1);
      send_slot(2, 1'b1, 32'h0BAD_0000, 25, 3, -1);
      send_slot(2, 1'b0, 32'hC001_8000, 25, 3, -1);
      push(2, 16'hC001);
      send_slot(2, 1'b1, 32'h0BAD_0000, 25, 3, -1);
      send_slot(2, 1'b0, 32'hC001_8000, 25, 3, -1);
      send_slot(2, 1'b1, 32'h0BAD_0000, 25, 3, -1);
      check("overrun_set", {15'd0, ovr_w[2]}, 16'h0001);
      send_slot(2, 1'b0, 32'hC001_8000, 25, 3, -1);
      push(2, 16'hC001);
      send_slot(2, 1'b1, 32'h0BAD_0000, 25, 3, -1);
      send_slot(2, 1'b0, 32'hC001_8000, 25, 3, -1);
      send_slot(2, 1'b1, 32'h0BAD_0000, 25, 3, -1);
      send_slot(2, 1'b0, 32'hC001_8000, 25, 3, -1);
      push(2, 16'hC001);
      send_slot(2, 1'b1, 32'h0BAD_0000, 25, 3, -1);
      check("gap_inst_no_frame_err", {15'd0, ferr_w[2]}, 16'h0000);
      check("gap_inst_data", data_w[2], 16'hC001);
      check("left_inst_no_overrun", {15'd0, ovr_w[0]}, 16'h0000);

      repeat (20) @(posedge clk);
      #1;
      check("missing_ticks_dut0", 16'(q0.size()), 16'd0);
      check("missing_ticks_dut1", 16'(q1.size()), 16'd0);
      check("missing_ticks_dut2", 16'(q2.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
